// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg
//   Shared types for the UART transmit-path arbiter.
//   - arb_state_t : arbiter FSM states (idle / grant held)
//   - req_id_t    : requester identifier (one bit, two requesters)
//   - REQ_MMIO    : memory controller MMIO UART write path
//   - REQ_DBG     : hardware debug / key-dump engine
package uart_tx_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_MMIO = 1'b0;
    localparam req_id_t REQ_DBG  = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_timer.sv
// arb_lock_timer
//   Counts consecutive idle cycles of the current grant owner. at_limit_o is
//   high while the count sits at LOCK_TIMEOUT-1; the parent qualifies it with
//   its own increment request, so one more idle cycle at that point is the
//   expiry cycle. The count clears itself on that expiry cycle.
// Parameters:
//   LOCK_TIMEOUT : idle cycles that force a release (2..65535)
//   TO_W         : counter width, 2**TO_W > LOCK_TIMEOUT
// Ports:
//   clk_50M    in   system clock
//   Rst        in   synchronous active-high reset
//   clr_i      in   restart the count (owner busy or grant ending)
//   inc_i      in   owner idle this cycle
//   at_limit_o out  count equals LOCK_TIMEOUT-1
module arb_lock_timer #(
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned TO_W         = 16
) (
    input  logic clk_50M,
    input  logic Rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(LOCK_TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    assign at_limit_o = (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (inc_i && at_limit_o)) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares the single UART transmit byte path between the MMIO write path
//   (requester 0) and the debug/key-dump engine (requester 1). A grant is
//   held for a whole packet (until a byte flagged last is accepted), packets
//   are granted round-robin, and a grant whose owner stays idle for
//   LOCK_TIMEOUT consecutive cycles is force-released.
// Optional build macro:
//   UART_TX_ARB_STATS_EN : adds saturating byte/timeout statistics outputs.
// Ports:
//   clk_50M, Rst              clock, synchronous active-high reset
//   req{0,1}_valid/data/last  requester byte streams (valid/ready)
//   req{0,1}_ready            byte accepted when valid & ready
//   tx_full                   UART TX FIFO full
//   tx_wen, uart_din          UART write strobe and data
//   grant_id, busy            current owner, grant held
//   timeout_evt               one-cycle pulse on forced release
//   stat_bytes0/1, stat_timeouts (stats build only)
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned TO_W         = 16
) (
    input  logic       clk_50M,
    input  logic       Rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    input  logic       tx_full,
    output logic       tx_wen,
    output logic [7:0] uart_din,
    output logic       grant_id,
    output logic       busy,
    output logic       timeout_evt
`ifdef UART_TX_ARB_STATS_EN
    ,
    output logic [15:0] stat_bytes0,
    output logic [15:0] stat_bytes1,
    output logic [7:0]  stat_timeouts
`endif
);

    arb_state_t state_q, state_d;
    req_id_t    owner_q, owner_d;
    req_id_t    prio_q,  prio_d;

    logic       owner_valid;
    logic       owner_last;
    logic [7:0] owner_data;
    logic       xfer;
    logic       ready0;
    logic       ready1;
    logic       to_clr;
    logic       to_inc;
    logic       to_at_limit;
    logic       to_expire;

    assign owner_valid = (owner_q == REQ_DBG) ? req1_valid : req0_valid;
    assign owner_last  = (owner_q == REQ_DBG) ? req1_last  : req0_last;
    assign owner_data  = (owner_q == REQ_DBG) ? req1_data  : req0_data;

    // Expiry needs an idle cycle on top of the count already at its limit.
    assign to_expire = to_inc & to_at_limit;

    arb_lock_timer #(
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .TO_W        (TO_W)
    ) u_lock_timer (
        .clk_50M   (clk_50M),
        .Rst       (Rst),
        .clr_i     (to_clr),
        .inc_i     (to_inc),
        .at_limit_o(to_at_limit)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        ready0      = 1'b0;
        ready1      = 1'b0;
        xfer        = 1'b0;
        tx_wen      = 1'b0;
        uart_din    = 8'h00;
        timeout_evt = 1'b0;
        // The idle counter only runs while a grant is held and its owner is
        // idle; every other cycle restarts it.
        to_clr      = 1'b1;
        to_inc      = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // Decide the owner now; the first byte moves next cycle.
                if (req0_valid && req1_valid) begin
                    owner_d = prio_q;
                    state_d = ARB_GRANT;
                end else if (req0_valid) begin
                    owner_d = REQ_MMIO;
                    state_d = ARB_GRANT;
                end else if (req1_valid) begin
                    owner_d = REQ_DBG;
                    state_d = ARB_GRANT;
                end
            end

            ARB_GRANT: begin
                ready0 = (owner_q == REQ_MMIO) && !tx_full;
                ready1 = (owner_q == REQ_DBG)  && !tx_full;
                xfer   = owner_valid && !tx_full;
                tx_wen = xfer;
                if (xfer) begin
                    uart_din = owner_data;
                    if (owner_last) begin
                        state_d = ARB_IDLE;
                        prio_d  = ~owner_q;
                    end
                end else if (!owner_valid) begin
                    // Owner valid but FIFO full is backpressure, not idleness.
                    to_clr = 1'b0;
                    to_inc = 1'b1;
                    if (to_expire) begin
                        timeout_evt = 1'b1;
                        state_d     = ARB_IDLE;
                        prio_d      = ~owner_q;
                    end
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign req0_ready = ready0;
    assign req1_ready = ready1;
    assign busy       = (state_q == ARB_GRANT);
    assign grant_id   = owner_q;

    always_ff @(posedge clk_50M) begin
        if (Rst) begin
            state_q <= ARB_IDLE;
            owner_q <= REQ_MMIO;
            prio_q  <= REQ_MMIO;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

`ifdef UART_TX_ARB_STATS_EN
    logic [15:0] stat_bytes0_q, stat_bytes0_d;
    logic [15:0] stat_bytes1_q, stat_bytes1_d;
    logic [7:0]  stat_timeouts_q, stat_timeouts_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        stat_bytes0_d   = stat_bytes0_q;
        stat_bytes1_d   = stat_bytes1_q;
        stat_timeouts_d = stat_timeouts_q;
        if (xfer && (owner_q == REQ_MMIO)) begin
            stat_bytes0_d = sat_inc16(stat_bytes0_q);
        end
        if (xfer && (owner_q == REQ_DBG)) begin
            stat_bytes1_d = sat_inc16(stat_bytes1_q);
        end
        if (timeout_evt) begin
            stat_timeouts_d = sat_inc8(stat_timeouts_q);
        end
    end

    always_ff @(posedge clk_50M) begin
        if (Rst) begin
            stat_bytes0_q   <= '0;
            stat_bytes1_q   <= '0;
            stat_timeouts_q <= '0;
        end else begin
            stat_bytes0_q   <= stat_bytes0_d;
            stat_bytes1_q   <= stat_bytes1_d;
            stat_timeouts_q <= stat_timeouts_d;
        end
    end

    assign stat_bytes0   = stat_bytes0_q;
    assign stat_bytes1   = stat_bytes1_q;
    assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios followed by randomized
// traffic. A cycle-level reference model predicts every output; bytes it
// expects on the UART are queued and a separate monitor pops them whenever
// the DUT strobes tx_wen.
module tb_uart_tx_arbiter;

    localparam int LT = 8;
    localparam int TW = 4;

    logic       clk_50M = 1'b0;
    logic       Rst     = 1'b1;
    logic       v   [2];
    logic [7:0] d   [2];
    logic       l   [2];
    logic       rdy0, rdy1;
    logic       tx_full = 1'b0;
    logic       tx_wen;
    logic [7:0] uart_din;
    logic       grant_id;
    logic       busy;
    logic       timeout_evt;
`ifdef UART_TX_ARB_STATS_EN
    logic [15:0] stat_bytes0, stat_bytes1;
    logic [7:0]  stat_timeouts;
`endif

    uart_tx_arbiter #(.LOCK_TIMEOUT(LT), .TO_W(TW)) dut (
        .clk_50M    (clk_50M),
        .Rst        (Rst),
        .req0_valid (v[0]),
        .req0_data  (d[0]),
        .req0_last  (l[0]),
        .req0_ready (rdy0),
        .req1_valid (v[1]),
        .req1_data  (d[1]),
        .req1_last  (l[1]),
        .req1_ready (rdy1),
        .tx_full    (tx_full),
        .tx_wen     (tx_wen),
        .uart_din   (uart_din),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_evt(timeout_evt)
`ifdef UART_TX_ARB_STATS_EN
        ,
        .stat_bytes0  (stat_bytes0),
        .stat_bytes1  (stat_bytes1),
        .stat_timeouts(stat_timeouts)
`endif
    );

    always #10 clk_50M = ~clk_50M;

    int checks  = 0;
    int errors  = 0;
    int wen_cnt = 0;
    bit chk_en  = 0;
    int exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner holds the UART for a packet; a new owner is
    // chosen from whoever is waiting, the preferred one on a tie; LT idle
    // cycles in a row end the grant.
    int m_grant = 0, m_owner = 0, m_prio = 0, m_idle = 0;
    int m_b0 = 0, m_b1 = 0, m_to = 0;

    always begin : model
        int ov, xf, eto, e0, e1;
        @(negedge clk_50M);
        if (chk_en) begin
            ov  = (m_owner == 1) ? int'(v[1]) : int'(v[0]);
            xf  = (m_grant == 1 && ov == 1 && !tx_full) ? 1 : 0;
            eto = (m_grant == 1 && ov == 0 && m_idle == LT - 1) ? 1 : 0;
            e0  = (m_grant == 1 && m_owner == 0 && !tx_full) ? 1 : 0;
            e1  = (m_grant == 1 && m_owner == 1 && !tx_full) ? 1 : 0;
            chk("busy", busy, m_grant);
            chk("grant_id", grant_id, m_owner);
            chk("req0_ready", rdy0, e0);
            chk("req1_ready", rdy1, e1);
            chk("tx_wen", tx_wen, xf);
            chk("timeout_evt", timeout_evt, eto);
            if (xf == 0) chk("uart_din_idle", uart_din, 0);
            if (xf == 1) exp_q.push_back(m_owner * 256 + int'(d[m_owner]));
`ifdef UART_TX_ARB_STATS_EN
            chk("stat_bytes0", stat_bytes0, m_b0);
            chk("stat_bytes1", stat_bytes1, m_b1);
            chk("stat_timeouts", stat_timeouts, m_to);
`endif
            if (Rst) begin
                m_grant = 0; m_owner = 0; m_prio = 0; m_idle = 0;
                m_b0 = 0; m_b1 = 0; m_to = 0;
            end else begin
                if (xf == 1) begin
                    if (m_owner == 0) m_b0++; else m_b1++;
                end
                if (eto == 1) m_to++;
                if (m_grant == 0) begin
                    if (v[0] && v[1]) begin m_owner = m_prio; m_grant = 1; end
                    else if (v[0])    begin m_owner = 0; m_grant = 1; end
                    else if (v[1])    begin m_owner = 1; m_grant = 1; end
                end else if (xf == 1) begin
                    m_idle = 0;
                    if (l[m_owner]) begin m_grant = 0; m_prio = 1 - m_owner; end
                end else if (ov == 0) begin
                    if (eto == 1) begin
                        m_grant = 0; m_prio = 1 - m_owner; m_idle = 0;
                    end else begin
                        m_idle++;
                    end
                end else begin
                    m_idle = 0;
                end
            end
        end
    end

    // Monitor: every UART write must match the oldest byte the model expects.
    always begin : monitor
        int e;
        @(negedge clk_50M);
        #1;
        if (chk_en && tx_wen === 1'b1) begin
            wen_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h required=none", uart_din);
            end else begin
                e = exp_q.pop_front();
                chk("uart_byte", uart_din, e % 256);
                chk("uart_owner", grant_id, e / 256);
            end
        end
    end

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    // Offer one byte and hold it until accepted (bounded).
    task automatic send_byte(input int id, input logic [7:0] b, input logic last);
        bit acc;
        acc   = 0;
        v[id] = 1'b1;
        d[id] = b;
        l[id] = last;
        for (int k = 0; k < 400 && !acc; k++) begin
            @(negedge clk_50M);
            acc = v[id] && ((id == 1) ? rdy1 : rdy0);
            tick();
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_wait actual=stuck required=accept id=%0d", id);
        end
        v[id] = 1'b0;
    endtask

    task automatic send_pkt(input int id, input int n, input int gapmax);
        int gap;
        for (int i = 0; i < n; i++) begin
            send_byte(id, 8'($urandom), (i == n - 1));
            gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic wait_wen(input int target);
        int k;
        k = 0;
        while (wen_cnt < target && k < 200) begin
            @(negedge clk_50M);
            #2;
            k++;
        end
        chk("wen_wait", (wen_cnt >= target), 1);
    endtask

    task automatic pulse_rst();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
    endtask

    bit rand_done = 0;

    initial begin
        int w0, lat;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; d[i] = 8'h00; l[i] = 1'b0;
        end
        tick();
        tick();
        chk_en = 1;
        tick();
        Rst = 1'b0;
        @(negedge clk_50M);
        chk("reset_busy", busy, 0);
        chk("reset_wen", tx_wen, 0);
        chk("reset_din", uart_din, 0);
        tick();

        // Single uncontested packet.
        w0 = wen_cnt;
        send_byte(0, 8'h48, 1'b0);
        send_byte(0, 8'h49, 1'b1);
        tick();
        chk("single_count", wen_cnt - w0, 2);
        tick();

        // Contention from reset: req0 packet first, then req1, no interleave.
        pulse_rst();
        w0 = wen_cnt;
        fork
            send_pkt(0, 3, 0);
            send_pkt(1, 3, 0);
        join
        tick();
        chk("contend_count", wen_cnt - w0, 6);

        // Backpressure: FIFO full for 5 cycles mid-packet.
        w0 = wen_cnt;
        fork
            send_pkt(0, 3, 0);
            begin
                wait_wen(w0 + 1);
                tick();
                tx_full = 1'b1;
                for (int i = 0; i < 5; i++) tick();
                tx_full = 1'b0;
            end
        join
        tick();
        chk("bp_count", wen_cnt - w0, 3);

        // Timeout: req1 sends one non-last byte then goes quiet; req0 waits.
        tick();
        tick();
        send_byte(1, 8'hAA, 1'b0);
        lat = 0;
        fork
            send_byte(0, 8'h55, 1'b1);
            begin
                for (int k = 1; k <= 20 && lat == 0; k++) begin
                    @(negedge clk_50M);
                    #1;
                    if (timeout_evt === 1'b1) lat = k;
                end
            end
        join
        chk("timeout_latency", lat, LT);
        tick();

        // Reset mid-packet; both request right after, prio must be back at 0.
        w0 = wen_cnt;
        fork
            send_pkt(0, 3, 0);
            begin
                wait_wen(w0 + 1);
                tick();
                Rst = 1'b1;
                tick();
                Rst = 1'b0;
                v[1] = 1'b1; d[1] = 8'h77; l[1] = 1'b1;
                @(negedge clk_50M);
                chk("rst_busy", busy, 0);
                chk("rst_wen", tx_wen, 0);
                chk("rst_ready0", rdy0, 0);
                chk("rst_ready1", rdy1, 0);
                send_byte(1, 8'h77, 1'b1);
            end
        join
        tick();

        // Randomized traffic with backpressure and occasional timeouts.
        fork
            begin
                fork
                    repeat (15) begin
                        for (int g = $urandom_range(0, 5); g > 0; g--) tick();
                        send_pkt(0, $urandom_range(1, 5), 10);
                    end
                    repeat (15) begin
                        for (int g = $urandom_range(0, 5); g > 0; g--) tick();
                        send_pkt(1, $urandom_range(1, 5), 10);
                    end
                join
                rand_done = 1;
            end
            while (!rand_done) begin
                tx_full = ($urandom_range(0, 3) == 0);
                tick();
            end
        join
        tx_full = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
